rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

Parametrised N-channel, WIDTH-bit arbitrating selector with a registered output stage and valid/ready handshakes on every port. It generalises the CPU's fixed 2:1 select muxes for places where several producers compete for one consumer, such as multi-source write-back or debug/bus request merging. It chooses one requesting channel per cycle, using round-robin or fixed-priority arbitration, and holds the chosen word until the consumer accepts it.

## Interface
- WIDTH, 5: data width per channel, ≥1.
- N, 4: number of input channels, ≥2.
- RR, 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- IDX_W, $clog2(N): derived width of channel index; not overridden.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  N  bit i high = channel i offers a word.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  bit i high = channel i word is taken this cycle; at most one bit high.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_src  output  IDX_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word when high together with out_valid.

## Operation
- One clock domain. The asynchronous active-low reset clears all registers immediately.
- Reset values: out_valid=0, out_data=0, out_src=0, priority pointer ptr=0.
- in_ready is combinational and is 0 during reset.
- Two-state control, implicit in out_valid:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load enable: `load_ok = !out_valid | out_ready`.
- Arbitration, evaluated every cycle:
  - RR=1: scan in_valid starting at ptr, ascending, wrapping N-1→0. The first set bit is the winner g.
  - RR=0: the winner is the lowest set index; ptr is ignored.
- Grant: `in_ready[g] = load_ok & in_valid[g]`. All other in_ready bits are 0. All bits are 0 when no in_valid bit is set.
- On a clock edge with a grant:
  - out_data ← in_data[g], out_src ← g, out_valid ← 1.
  - RR=1: ptr ← (g+1) mod N. When g=N-1, ptr wraps to 0.
- On a clock edge with no grant:
  - If out_valid & out_ready: out_valid ← 0. out_data and out_src keep their values.
  - Otherwise every register holds.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→FULL on accept+grant (back-to-back), or on stall.
  - FULL→EMPTY on accept with no request.
- Stall (out_valid=1, out_ready=0):
  - out_data and out_src stay stable.
  - All in_ready bits are 0.
  - ptr is frozen.
- ptr moves only on a grant, never on a request alone.
- A channel that drops in_valid without a grant loses nothing and gets no advantage.
- Reset asserted mid-transfer discards the held word. After release the block behaves as just out of reset.

## Timing
- Latency: a word granted in cycle t is presented on out_valid/out_data in cycle t+1.
- Throughput: one word per cycle while out_ready=1 and any request is present.
- Combinational paths in_valid→in_ready and out_ready→in_ready are permitted. There is no path from any input to out_*.
- Fairness (RR=1): a continuously requesting channel is granted within N grants.
- Simultaneous consumer accept and new grant in the same cycle: the new word replaces the old one with no bubble.

## Test plan
- Reset: hold rst_n=0 with in_valid=4'b1111.
  -> out_valid=0, out_data=0, out_src=0, in_ready=0.
  - Release rst_n with only ch2 valid, data 5'h15 -> next cycle out_valid=1, out_data=5'h15, out_src=2.
- Round-robin rotation (RR=1): all 4 channels valid, data 5'h01..5'h04, out_ready=1.
  -> out_src sequence 0,1,2,3,0 on consecutive cycles; exactly one in_ready bit high each cycle.
- Wrap and skip: ptr=3, in_valid=4'b0101.
  -> grant ch0 (wrap past 3); next grant ch2.
- Back-pressure: out_ready=0 for 3 cycles while ch1 holds 5'h1A.
  -> out_data=5'h1A and out_src=1 stay stable; in_ready=0; ptr unchanged.
  - Raise out_ready -> accepted, then the next grant follows with no bubble.
- Fixed priority (RR=0): in_valid=4'b1110 held, out_ready=1.
  -> out_src=1 every cycle; ch2 and ch3 are never granted.
- Reset mid-operation: assert rst_n=0 asynchronously while FULL.
  -> out_valid drops to 0 before the next clk edge, and ptr=0 after release.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel arbitrating selector with registered valid/ready output stage
module rr_arb_mux #(
    parameter int WIDTH = 5,
    parameter int N     = 4,
    parameter int RR    = 1,
    parameter int IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDX_W-1:0]   out_src,
    input  logic               out_ready
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] idx;
    logic             any_req;
    logic             load_ok;
    logic             grant;
    int               j;

    // Scan from ptr (round-robin) or from 0 (fixed priority); first requester wins.
    always_comb begin
        win     = '0;
        idx     = '0;
        any_req = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (RR != 0) ? int'(ptr) + k : k;
            if (j >= N) begin
                j = j - N;
            end
            idx = IDX_W'(j);
            if (!any_req && in_valid[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

    assign load_ok  = !out_valid || out_ready;
    assign grant    = rst_n && load_ok && any_req;
    assign in_ready = grant ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= in_data[win*WIDTH +: WIDTH];
            out_src   <= win;
            if (RR != 0) begin
                ptr <= (win == IDX_W'(N-1)) ? '0 : win + 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - randomized and directed check of rr_arb_mux against a reference model
module tb_rr_arb_mux;
    localparam int W  = 5;
    localparam int N  = 4;
    localparam int IW = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N-1:0]            in_valid;
    logic [N*W-1:0]          in_data;
    logic                    out_ready;
    logic [1:0][N-1:0]       rdy;
    logic [1:0]              ov;
    logic [1:0][W-1:0]       od;
    logic [1:0][IW-1:0]      os;

    int vectors = 0;
    int miscompares = 0;

    // Index 0 = fixed priority, index 1 = round-robin.
    int       m_ptr   [2];
    bit       m_valid [2];
    int       m_data  [2];
    int       m_src   [2];

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(W), .N(N), .RR(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_src(os[0]),
        .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(W), .N(N), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_src(os[1]),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input int d, input logic [N-1:0] v);
        int order[$];
        int w;
        w = -1;
        for (int k = 0; k < N; k++) order.push_back((d == 1) ? (m_ptr[d] + k) % N : k);
        for (int i = 0; i < N; i++) begin
            if (w < 0 && v[order[i]]) w = order[i];
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_valid[d] = 0; m_data[d] = 0; m_src[d] = 0;
        end
    endtask

    task automatic set_data(input int c0, input int c1, input int c2, input int c3);
        in_data = {W'(c3), W'(c2), W'(c1), W'(c0)};
    endtask

    // One clock: check in_ready before the edge, outputs after it.
    task automatic cycle();
        int w [2];
        logic [N-1:0] er;
        #1;
        for (int d = 0; d < 2; d++) begin
            w[d] = (rst_n && (!m_valid[d] || out_ready)) ? winner(d, in_valid) : -1;
            er = (w[d] >= 0) ? N'(1 << w[d]) : '0;
            chk(d ? "rr_in_ready" : "fp_in_ready", 32'(rdy[d]), 32'(er));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_ptr[d] = 0; m_valid[d] = 0; m_data[d] = 0; m_src[d] = 0;
            end else if (w[d] >= 0) begin
                m_valid[d] = 1;
                m_data[d]  = int'(in_data[w[d]*W +: W]);
                m_src[d]   = w[d];
                if (d == 1) m_ptr[d] = (w[d] + 1) % N;
            end else if (m_valid[d] && out_ready) begin
                m_valid[d] = 0;
            end
            chk(d ? "rr_out_valid" : "fp_out_valid", 32'(ov[d]), 32'(m_valid[d]));
            chk(d ? "rr_out_data"  : "fp_out_data",  32'(od[d]), 32'(m_data[d]));
            chk(d ? "rr_out_src"   : "fp_out_src",   32'(os[d]), 32'(m_src[d]));
        end
    endtask

    initial begin
        int exp_seq [5];
        exp_seq = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b0;
        set_data(1, 2, 3, 4);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(ov[1]), 0);
        chk("rst_out_data",  32'(od[1]), 0);
        chk("rst_out_src",   32'(os[1]), 0);
        chk("rst_in_ready",  32'(rdy[1]), 0);
        chk("rst_in_ready_fp", 32'(rdy[0]), 0);

        rst_n = 1'b1; in_valid = 4'b0100; out_ready = 1'b1;
        set_data(0, 0, 5'h15, 0);
        cycle();
        chk("first_valid", 32'(ov[1]), 1);
        chk("first_data",  32'(od[1]), 32'h15);
        chk("first_src",   32'(os[1]), 2);

        // ptr is now 3: wrap past 3 to ch0, then ch2.
        in_valid = 4'b0101; set_data(7, 8, 9, 10);
        cycle();
        chk("wrap_src0", 32'(os[1]), 0);
        cycle();
        chk("wrap_src2", 32'(os[1]), 2);

        in_valid = 4'b1000;
        cycle();
        in_valid = 4'b1111; set_data(1, 2, 3, 4);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rotate_src", 32'(os[1]), 32'(exp_seq[i]));
        end

        // Back-pressure with ch1 holding 5'h1A; ptr is 1 here.
        in_valid = 4'b0010; set_data(0, 5'h1A, 0, 0);
        cycle();
        out_ready = 1'b0; in_valid = 4'b1111; set_data(5'h11, 5'h12, 5'h13, 5'h14);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_data", 32'(od[1]), 32'h1A);
            chk("stall_src",  32'(os[1]), 1);
        end
        out_ready = 1'b1;
        cycle();
        chk("nobubble_valid", 32'(ov[1]), 1);
        chk("nobubble_src",   32'(os[1]), 2);
        chk("nobubble_data",  32'(od[1]), 32'h13);

        in_valid = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("fixed_src", 32'(os[0]), 1);
        end

        for (int i = 0; i < 400; i++) begin
            in_valid  = N'($urandom);
            in_data   = (N*W)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                #1;
                chk("rand_async_rst", 32'(ov[1]), 0);
                model_reset();
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        // Async reset while FULL: out_valid falls before the next edge.
        in_valid = 4'b1111; out_ready = 1'b0;
        cycle();
        chk("full_before_rst", 32'(ov[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(ov[1]), 0);
        chk("async_rst_valid_fp", 32'(ov[0]), 0);
        model_reset();
        cycle();
        rst_n = 1'b1; out_ready = 1'b1; set_data(5'h05, 5'h06, 5'h07, 5'h08);
        cycle();
        chk("post_rst_src",  32'(os[1]), 0);
        chk("post_rst_data", 32'(od[1]), 32'h05);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
